// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared widths and default constants for the ADC capture / DAC generator pair
package adc_capture_pkg;

    localparam int SAMPLE_W  = 12;
    localparam int PERIOD_W  = 16;
    localparam int DEF_DIV   = 5;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_MID   = 2048;

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

endpackage

// File: rtl/zc_period.sv
// rtl/zc_period.sv - single-channel rising mid-scale crossing detector with saturating period counter
module zc_period
    import adc_capture_pkg::*;
#(
    parameter int MID = DEF_MID
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clr,
    input  logic                sample_stb,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam logic [SAMPLE_W-1:0] MID_CODE = SAMPLE_W'(MID);

    logic [SAMPLE_W-1:0] prev_q;
    logic                prev_v_q;
    logic                armed_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic [PERIOD_W-1:0] period_q;
    logic                pv_q;
    logic                crossing;

    assign cnt_d    = (cnt_q == PERIOD_MAX) ? cnt_q : cnt_q + 1'b1;
    assign crossing = sample_stb && prev_v_q && (prev_q < MID_CODE) && (sample >= MID_CODE);

    // The first crossing after reset or enable rise only re-arms; a period needs two crossings.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            prev_v_q <= 1'b0;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
        end else begin
            pv_q <= 1'b0;
            if (!enable) begin
                prev_v_q <= 1'b0;
                armed_q  <= 1'b0;
            end else if (sample_stb) begin
                prev_q   <= sample;
                prev_v_q <= 1'b1;
                if (crossing) begin
                    cnt_q   <= '0;
                    armed_q <= 1'b1;
                    if (armed_q) begin
                        period_q <= cnt_d;
                        pv_q     <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_d;
                end
            end
            if (clr) begin
                period_q <= '0;
                pv_q     <= 1'b0;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - dual-channel ADC capture: sample clock, pair FIFO, overflow flag, per-channel period
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int DEPTH = DEF_DEPTH,
    parameter int MID   = DEF_MID
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clr,
    output logic                adc_clk,
    input  logic [SAMPLE_W-1:0] adcr,
    input  logic [SAMPLE_W-1:0] adcl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_datar,
    output logic [SAMPLE_W-1:0] out_datal,
    output logic                overflow,
    output logic [PERIOD_W-1:0] periodr,
    output logic [PERIOD_W-1:0] periodl,
    output logic                period_validr,
    output logic                period_validl
);

    localparam int              PH_W    = $clog2(DIV);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(DIV / 2);
    localparam logic [AW:0]     FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     ONE     = (AW + 1)'(1);

    logic [PH_W-1:0]     phase_q, phase_d;
    logic                adc_clk_q;
    logic                capture;
    logic                cap_v_q;
    logic [SAMPLE_W-1:0] cap_r_q, cap_l_q;
    logic [SAMPLE_W-1:0] mem_r_q [DEPTH];
    logic [SAMPLE_W-1:0] mem_l_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q, count_d;
    logic                out_valid_q, out_valid_d;
    logic                overflow_q;
    logic                pop, push_ok, drop;

    assign capture = enable && (phase_q == PH_LAST);
    assign pop     = out_valid_q && out_ready;
    assign push_ok = cap_v_q && ((count_q != FULL) || pop);
    assign drop    = cap_v_q && (count_q == FULL) && !pop;

    always_comb begin
        phase_d = '0;
        if (enable) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
    end

    // Valid follows stored occupancy one edge late, giving the fixed capture-to-valid latency.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        out_valid_d = pop ? (count_q > ONE) : (count_q != '0);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            adc_clk_q   <= 1'b0;
            cap_v_q     <= 1'b0;
            cap_r_q     <= '0;
            cap_l_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            adc_clk_q   <= enable && (phase_d < PH_HALF);
            cap_v_q     <= capture;
            if (capture) begin
                cap_r_q <= adcr;
                cap_l_q <= adcl;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            if (clr) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // When full, the write slot equals the slot being popped on the same edge, which is safe.
    always_ff @(posedge clkin) begin
        if (push_ok) begin
            mem_r_q[wr_ptr_q] <= cap_r_q;
            mem_l_q[wr_ptr_q] <= cap_l_q;
        end
    end

    assign adc_clk   = adc_clk_q;
    assign out_valid = out_valid_q;
    assign out_datar = out_valid_q ? mem_r_q[rd_ptr_q] : '0;
    assign out_datal = out_valid_q ? mem_l_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;

    zc_period #(.MID(MID)) u_zc_r (
        .clkin        (clkin),
        .rst_n        (rst_n),
        .enable       (enable),
        .clr          (clr),
        .sample_stb   (capture),
        .sample       (adcr),
        .period       (periodr),
        .period_valid (period_validr)
    );

    zc_period #(.MID(MID)) u_zc_l (
        .clkin        (clkin),
        .rst_n        (rst_n),
        .enable       (enable),
        .clr          (clr),
        .sample_stb   (capture),
        .sample       (adcl),
        .period       (periodl),
        .period_valid (period_validl)
    );

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - scoreboard bench for adc_capture with a cycle-level reference model
module tb_adc_capture;
    import adc_capture_pkg::*;

    localparam int DIV   = 5;
    localparam int DEPTH = 16;
    localparam int MID   = 2048;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] adcr = '0;
    logic [11:0] adcl = '0;
    logic        adc_clk, out_valid, overflow, period_validr, period_validl;
    logic [11:0] out_datar, out_datal;
    logic [15:0] periodr, periodl;

    logic        zc_en = 1'b0;
    logic        zc_stb = 1'b0;
    logic [11:0] zc_s = '0;
    logic [15:0] zc_p;
    logic        zc_pv;

    always #5 clkin = ~clkin;

    adc_capture #(.DIV(DIV), .DEPTH(DEPTH), .MID(MID)) dut (
        .clkin(clkin), .rst_n(rst_n), .enable(enable), .clr(clr), .adc_clk(adc_clk),
        .adcr(adcr), .adcl(adcl), .out_valid(out_valid), .out_ready(out_ready),
        .out_datar(out_datar), .out_datal(out_datal), .overflow(overflow),
        .periodr(periodr), .periodl(periodl),
        .period_validr(period_validr), .period_validl(period_validl)
    );

    zc_period #(.MID(MID)) u_zc (
        .clkin(clkin), .rst_n(rst_n), .enable(zc_en), .clr(1'b0),
        .sample_stb(zc_stb), .sample(zc_s), .period(zc_p), .period_valid(zc_pv)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] r;
        logic [11:0] l;
        int          cyc;
    } pair_t;

    pair_t exp_q[$];
    int    per_r[$];
    int    per_l[$];
    pair_t pend, e;
    bit    pend_v = 0;
    bit    exp_ovf = 0;
    bit    m_pop;
    int    cyc = 0, since_en = 0, occ = 0, cap_count = 0;
    int    idx[2], last_x[2];
    bit    had_prev[2];
    logic [11:0] prev_s[2];

    // Period = distance in capture indices between consecutive rising crossings.
    task automatic crossing_model(input int c, input logic [11:0] s);
        int p;
        if (had_prev[c] && prev_s[c] < MID && s >= MID) begin
            if (last_x[c] >= 0) begin
                p = idx[c] - last_x[c];
                if (p > 65535) p = 65535;
                if (c == 0) per_r.push_back(p);
                else        per_l.push_back(p);
            end
            last_x[c] = idx[c];
        end
        prev_s[c]   = s;
        had_prev[c] = 1;
        idx[c]++;
    endtask

    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            since_en = 0; pend_v = 0; occ = 0; exp_ovf = 0;
            exp_q.delete(); per_r.delete(); per_l.delete();
            for (int c = 0; c < 2; c++) begin
                had_prev[c] = 0; last_x[c] = -1; idx[c] = 0;
            end
        end else begin
            cyc++;
            m_pop = out_valid && out_ready;
            if (pend_v) begin
                if (occ < DEPTH || m_pop) begin
                    exp_q.push_back(pend);
                    occ++;
                end else begin
                    exp_ovf = 1;
                end
                pend_v = 0;
            end
            if (m_pop) occ--;
            if (clr) exp_ovf = 0;
            if (enable) begin
                if (since_en % DIV == DIV - 1) begin
                    pend_v = 1; pend.r = adcr; pend.l = adcl; pend.cyc = cyc;
                    cap_count++;
                    crossing_model(0, adcr);
                    crossing_model(1, adcl);
                end
                since_en++;
            end else begin
                since_en = 0;
                for (int c = 0; c < 2; c++) begin
                    had_prev[c] = 0; last_x[c] = -1;
                end
            end
        end
    end

    bit          lat_chk = 0, ramp_chk = 0, ramp_have = 0;
    logic [11:0] ramp_last;
    int          n_pop = 0, n_pvl = 0;

    always @(negedge clkin) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("pop_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_datar", out_datar, e.r);
                    check("out_datal", out_datal, e.l);
                    if (lat_chk) check("valid_latency", cyc - e.cyc, 2);
                end
                if (ramp_chk) begin
                    if (ramp_have) check("ramp_step", out_datar, 12'(ramp_last + 12'd1));
                    ramp_last = out_datar;
                    ramp_have = 1;
                end
                n_pop++;
            end else if (out_valid && exp_q.size() > 0) begin
                check("head_stable_r", out_datar, exp_q[0].r);
                check("head_stable_l", out_datal, exp_q[0].l);
            end
            if (period_validr) begin
                check("pvr_expected", per_r.size() > 0, 1);
                if (per_r.size() > 0) check("periodr", periodr, per_r.pop_front());
            end
            if (period_validl) begin
                check("pvl_expected", per_l.size() > 0, 1);
                if (per_l.size() > 0) check("periodl", periodl, per_l.pop_front());
                n_pvl++;
            end
        end
    end

    int mode = 0;
    int dcyc = 0;
    initial begin
        int k;
        forever begin
            @(posedge clkin); #1;
            dcyc++;
            k = dcyc / DIV;
            case (mode)
                1: begin
                    adcr = 12'(100 + k);
                    adcl = 12'($urandom_range(0, 4095));
                end
                2: begin
                    adcr = 12'($urandom_range(0, 4095));
                    adcl = ((k / 4) % 2 == 1) ? 12'd2100 : 12'd2000;
                end
                default: begin
                    adcr = 12'($urandom_range(0, 4095));
                    adcl = 12'($urandom_range(0, 4095));
                end
            endcase
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, hi, nb, rel;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_adc_clk", adc_clk, 0);
        check("rst_overflow", overflow, 0);
        check("rst_periodr", periodr, 0);
        check("rst_out_datar", out_datar, 0);
        repeat (3) @(posedge clkin);
        #1 rst_n = 1'b1;

        // ramp, always ready
        mode = 1; out_ready = 1; lat_chk = 1; ramp_chk = 1; enable = 1;
        repeat (4) @(posedge clkin);
        hi = 0;
        repeat (10 * DIV) begin
            @(negedge clkin);
            hi += adc_clk;
        end
        check("adc_clk_high_count", hi, 10 * (DIV / 2));
        repeat (40 * DIV) @(posedge clkin);
        #1;
        check("ramp_pairs_seen", n_pop >= 40, 1);
        ramp_chk = 0; lat_chk = 0;

        // square wave on left channel after an enable restart
        enable = 0;
        repeat (3) @(posedge clkin);
        #1 mode = 2; enable = 1;
        nb = n_pvl;
        repeat (100 * DIV) @(posedge clkin);
        #1;
        check("periodl_square", periodl, 8);
        check("square_pulses", n_pvl - nb >= 10, 1);

        // fill with ready low: 16 kept, 17th dropped
        t = 0;
        while ((exp_q.size() != 0 || pend_v) && t < 200) begin
            @(posedge clkin); #1; t++;
        end
        check("idle_before_fill", t < 200, 1);
        out_ready = 0;
        nb = cap_count;
        t = 0;
        while (cap_count < nb + 16 && t < 200) begin @(posedge clkin); #1; t++; end
        repeat (2) @(posedge clkin);
        #1 check("ovf_after_16", overflow, 0);
        while (cap_count < nb + 17 && t < 300) begin @(posedge clkin); #1; t++; end
        repeat (2) @(posedge clkin);
        #1 check("ovf_after_17", overflow, 1);
        while (cap_count < nb + 20 && t < 400) begin @(posedge clkin); #1; t++; end
        check("fill_timeout", t < 400, 1);
        enable = 0;
        repeat (2) @(posedge clkin);
        #1;
        check("ovf_model", overflow, exp_ovf);
        check("adc_clk_idle", adc_clk, 0);
        out_ready = 1;
        nb = n_pop;
        repeat (60) @(posedge clkin);
        #1;
        check("drain_count", n_pop - nb, 16);
        check("drained_valid", out_valid, 0);

        check("periodl_before_clr", periodl, 8);
        clr = 1;
        @(posedge clkin); #1 clr = 0;
        check("clr_overflow", overflow, 0);
        check("clr_periodr", periodr, 0);
        check("clr_periodl", periodl, 0);

        // full FIFO with a transfer on the push edge
        out_ready = 0; enable = 1;
        t = 0;
        while (exp_q.size() < 16 && t < 200) begin @(posedge clkin); #1; t++; end
        while (!pend_v && t < 220) begin @(posedge clkin); #1; t++; end
        check("full_wait_timeout", t < 220, 1);
        out_ready = 1;
        @(posedge clkin); #1;
        out_ready = 0; enable = 0;
        check("full_pushpop_ovf", overflow, 0);
        check("full_pushpop_occ", exp_q.size(), 16);
        repeat (2) @(posedge clkin);
        #1 out_ready = 1;
        nb = n_pop;
        repeat (60) @(posedge clkin);
        #1 check("full_drain_count", n_pop - nb, 16);

        // reset with five pairs buffered
        mode = 0; out_ready = 0; enable = 1;
        t = 0;
        while (exp_q.size() < 5 && t < 100) begin @(posedge clkin); #1; t++; end
        check("buffer5_timeout", t < 100, 1);
        #3 rst_n = 0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_datar", out_datar, 0);
        check("mid_rst_datal", out_datal, 0);
        check("mid_rst_adc_clk", adc_clk, 0);
        check("mid_rst_periodl", periodl, 0);
        @(posedge clkin); #1;
        rst_n = 1; out_ready = 1; lat_chk = 1;
        rel = cyc;
        t = 0;
        do begin @(negedge clkin); t++; end while (!out_valid && t < 30);
        check("restart_latency", cyc - rel, DIV + 2);
        repeat (10 * DIV) @(posedge clkin);
        #1 enable = 0; lat_chk = 0;
        repeat (20) @(posedge clkin);
        #1;
        check("leftover_pairs", exp_q.size(), 0);
        check("leftover_periodr", per_r.size(), 0);
        check("leftover_periodl", per_l.size(), 0);

        // saturating period counter, one sample per cycle
        zc_en = 1; zc_stb = 1;
        foreach_sample(100); foreach_sample(3000);
        foreach_sample(100); foreach_sample(100); foreach_sample(100);
        foreach_sample(3000);
        check("zc_period_small", zc_p, 4);
        check("zc_pulse", zc_pv, 1);
        foreach_sample(100);
        check("zc_pulse_one_cycle", zc_pv, 0);
        repeat (65600) foreach_sample(100);
        foreach_sample(3000);
        check("zc_period_saturated", zc_p, 65535);
        check("zc_pulse_sat", zc_pv, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic foreach_sample(input logic [11:0] s);
        zc_s = s;
        @(posedge clkin); #1;
    endtask

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter DIV, default 5, clkin cycles per ADC sample period (integer, >=2).
REQ-002 Parameter DEPTH, default 16, sample-pair FIFO depth (power of two).
REQ-003 Parameter MID, default 2048, 12-bit mid-scale code used for zero-crossing detection.
REQ-004 clkin  in  1  sole clock, 50 MHz domain; all logic on posedge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 enable  in  1  capture enable, level.
REQ-007 clr  in  1  synchronous single-cycle clear of overflow flag and period outputs.
REQ-008 adc_clk  out  1  sample clock to both ADCs.
REQ-009 adcr  in  12  right-channel ADC code, unsigned offset binary.
REQ-010 adcl  in  12  left-channel ADC code, unsigned offset binary.
REQ-011 out_valid  out  1  FIFO head holds a sample pair.
REQ-012 out_ready  in  1  consumer accepts head pair.
REQ-013 out_datar  out  12  right sample at FIFO head.
REQ-014 out_datal  out  12  left sample at FIFO head.
REQ-015 overflow  out  1  sticky: a captured pair was dropped.
REQ-016 periodr, periodl  out  16 each  last measured rising-crossing period, in samples.
REQ-017 period_validr, period_validl  out  1 each  single-cycle strobe when the matching period updates.

Function
REQ-018 Phase counter SHALL count 0..DIV-1 and wrap while enable=1; held at 0 while enable=0.
REQ-019 adc_clk SHALL be registered, high for phase in [0, DIV/2) (integer division), low otherwise, and low while enable=0.
REQ-020 adcr/adcl SHALL be captured together on the clkin edge where phase==DIV-1 and enable=1.
REQ-021 Captured pair SHALL be pushed into the FIFO on the following edge; out_valid SHALL rise one cycle after push when FIFO was empty (capture-to-valid latency 2 cycles).
REQ-022 Transfer occurs on an edge with out_valid=1 and out_ready=1; out_data* SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Push into a full FIFO SHALL succeed if a transfer occurs on the same edge; otherwise the pair is dropped and overflow SHALL set.
REQ-024 Push and pop on the same edge with FIFO empty is impossible (out_valid=0); occupancy unchanged when both occur otherwise.
REQ-025 FIFO SHALL continue draining while enable=0.
REQ-026 Per channel: rising crossing when previous captured sample < MID and current >= MID; none detected on the first capture after reset or enable rise.
REQ-027 Per channel 16-bit sample counter SHALL increment per capture, saturating at 65535; on a crossing, period<=counter value including the current sample, counter<=0, period_valid pulses one cycle.
REQ-028 First crossing after reset/enable rise SHALL only restart the counter, not update period or pulse period_valid.
REQ-029 clr SHALL zero overflow, periodr, periodl; clr has priority over a same-cycle set/update.
REQ-030 enable falling mid-period SHALL discard any capture not yet at phase DIV-1; already-captured pairs still pushed.

Reset
REQ-031 rst_n low SHALL immediately force: phase 0, adc_clk 0, FIFO empty, out_valid 0, out_data* 0, overflow 0, periods 0, period_valid* 0, counters 0, previous-sample-valid 0.
REQ-032 Reset mid-transfer SHALL discard FIFO contents; first capture after release occurs DIV cycles after enable is seen high.

Structure
REQ-033 Shared package SHALL hold SAMPLE_W=12, PERIOD_W=16, and default DIV/DEPTH/MID constants, shared with the DAC generator.
REQ-034 One sub-module zc_period (single channel crossing detector plus period counter) SHALL be instantiated twice; FIFO inline.

Verification
REQ-035 DIV=5, enable=1, adcr ramp +1 per sample, out_ready=1 -> adc_clk 2 high/3 low, out_valid 2 cycles after each capture edge, data matches ramp in order.
REQ-036 out_ready=0 for 20 samples, DEPTH=16 -> 16 pairs stored, overflow=1 at 17th capture, first 16 pairs read back intact.
REQ-037 Full FIFO with out_ready=1 on the push edge -> no overflow, occupancy stays 16.
REQ-038 adcl square wave 2000/2100 with 8-sample period -> first crossing silent, then periodl=8 with one-cycle period_validl per crossing.
REQ-039 adcr constant 100 for 70000 samples then crossing -> periodr=65535 (saturated).
REQ-040 rst_n pulsed low mid-stream with 5 pairs buffered -> out_valid 0 asynchronously, all outputs zero, capture resumes DIV cycles after release.
